rv32_regfile: RTL and testbench

Architectural register file and write-tracking scoreboard for the RV32 pipeline. It is the receiving end of the writeback interface: it accepts `reg_write`/`rd`/`wb_data` from the writeback stage and serves the decode stage. Decode gets two combinational read ports with same-cycle write bypass. It also gets per-register busy flags derived from a pending-write counter scoreboard, which decode uses to stall on RAW hazards.

---
 rtl/rv32_regfile_pkg.sv | 16 +
 rtl/rv32_regfile_if.sv | 34 +++
 rtl/rv32_reg_scoreboard.sv | 82 ++++++++
 rtl/rv32_regfile.sv | 65 ++++++
 tb/tb_rv32_regfile.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_regfile_pkg.sv
// Shared RV32 types for the register file and its writeback/decode interface.
package rv32_regfile_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RV_NUM_REGS = 32;
  localparam int unsigned REG_ID_W    = $clog2(RV_NUM_REGS);

  typedef logic [XLEN-1:0]     rv32_word;
  typedef logic [REG_ID_W-1:0] rv_reg_id_t;

  // x0 is hardwired; most paths need to know whether a register id is real.
  function automatic logic reg_nz(input rv_reg_id_t r);
    return r != '0;
  endfunction

endpackage

// File: rtl/rv32_regfile_if.sv
// Writeback, decode-read and issue-tracking signals between the pipeline and the register file.
interface rv32_regfile_if;
  import rv32_regfile_pkg::*;

  logic       reg_write;
  rv_reg_id_t rd;
  rv32_word   wb_data;

  rv_reg_id_t rs1;
  rv_reg_id_t rs2;
  rv32_word   rs1_data;
  rv32_word   rs2_data;
  logic       rs1_busy;
  logic       rs2_busy;

  logic       issue_valid;
  logic       issue_reg_write;
  rv_reg_id_t issue_rd;
  logic       flush;
  logic       sb_error;

  modport master (
    output reg_write, rd, wb_data, rs1, rs2,
    output issue_valid, issue_reg_write, issue_rd, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, sb_error
  );

  modport slave (
    input  reg_write, rd, wb_data, rs1, rs2,
    input  issue_valid, issue_reg_write, issue_rd, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, sb_error
  );

endinterface

// File: rtl/rv32_reg_scoreboard.sv
// Per-register pending-write counters: issue increments, writeback decrements,
// flush clears; produces RAW busy flags for decode and a sticky overflow error.
module rv32_reg_scoreboard
  import rv32_regfile_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic       issue_reg_write,
  input  rv_reg_id_t issue_rd,
  input  logic       reg_write,
  input  rv_reg_id_t rd,
  input  logic       flush,
  input  rv_reg_id_t rs1,
  input  rv_reg_id_t rs2,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       sb_error
);

  localparam int unsigned      CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]       pend_q [RV_NUM_REGS];
  logic [CNT_W-1:0]       pend_d [RV_NUM_REGS];
  logic                   inc;
  logic                   dec;
  logic [RV_NUM_REGS-1:0] inc_vec;
  logic [RV_NUM_REGS-1:0] dec_vec;
  logic                   overflow;

  assign inc     = issue_valid && issue_reg_write && reg_nz(issue_rd);
  assign dec     = reg_write && reg_nz(rd);
  assign inc_vec = inc ? (RV_NUM_REGS'(1) << issue_rd) : '0;
  assign dec_vec = dec ? (RV_NUM_REGS'(1) << rd) : '0;

  // Next counter values; flush wins over any same-cycle issue or retirement.
  always_comb begin
    overflow = 1'b0;
    for (int unsigned r = 0; r < RV_NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      if (r == 0 || flush) begin
        pend_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        if (pend_q[r] == CNT_MAX) begin
          overflow = 1'b1;
        end else begin
          pend_d[r] = pend_q[r] + CNT_ONE;
        end
      end else if (dec_vec[r] && !inc_vec[r]) begin
        // Retirements of pre-flush instructions arrive with the count already at 0.
        if (pend_q[r] != '0) begin
          pend_d[r] = pend_q[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < RV_NUM_REGS; r++) begin
        pend_q[r] <= '0;
      end
      sb_error <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (overflow) begin
        sb_error <= 1'b1;
      end
    end
  end

  // The final outstanding write retiring this cycle is served by the bypass, so no stall.
  assign rs1_busy = reg_nz(rs1) && (pend_q[rs1] != '0) &&
                    !(dec_vec[rs1] && pend_q[rs1] == CNT_ONE);
  assign rs2_busy = reg_nz(rs2) && (pend_q[rs2] != '0) &&
                    !(dec_vec[rs2] && pend_q[rs2] == CNT_ONE);

endmodule

// File: rtl/rv32_regfile.sv
// RV32 architectural register file: x1-x31 storage, two bypassed read ports,
// and the pending-write scoreboard used by decode for RAW stalls.
module rv32_regfile
  import rv32_regfile_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic           clk,
  input  logic           reset,
  rv32_regfile_if.slave  bus
);

  rv32_word regs_q [RV_NUM_REGS];
  logic     wr_en;

  assign wr_en = bus.reg_write && reg_nz(bus.rd);

  // Entry 0 is never written so it stays at its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < RV_NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.rd] <= bus.wb_data;
    end
  end

  function automatic rv32_word read_port(
    input rv_reg_id_t rs,
    input logic       we,
    input rv_reg_id_t wr_id,
    input rv32_word   wr_data,
    input rv32_word   stored
  );
    if (!reg_nz(rs)) begin
      return '0;
    end else if (we && wr_id == rs) begin
      return wr_data;
    end
    return stored;
  endfunction

  assign bus.rs1_data = read_port(bus.rs1, bus.reg_write, bus.rd, bus.wb_data, regs_q[bus.rs1]);
  assign bus.rs2_data = read_port(bus.rs2, bus.reg_write, bus.rd, bus.wb_data, regs_q[bus.rs2]);

  rv32_reg_scoreboard #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (bus.issue_valid),
    .issue_reg_write (bus.issue_reg_write),
    .issue_rd        (bus.issue_rd),
    .reg_write       (bus.reg_write),
    .rd              (bus.rd),
    .flush           (bus.flush),
    .rs1             (bus.rs1),
    .rs2             (bus.rs2),
    .rs1_busy        (bus.rs1_busy),
    .rs2_busy        (bus.rs2_busy),
    .sb_error        (bus.sb_error)
  );

endmodule

// File: tb/tb_rv32_regfile.sv
// Directed, table-driven bench for rv32_regfile: one table row per clock cycle,
// outputs compared mid-cycle against hand-computed values.
module tb_rv32_regfile;
  import rv32_regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;

  rv32_regfile_if bus();

  rv32_regfile #(.MAX_INFLIGHT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rw;
    rv_reg_id_t rd;
    rv32_word   wd;
    logic       iv;
    logic       irw;
    rv_reg_id_t ird;
    logic       fl;
    rv_reg_id_t rs1;
    rv_reg_id_t rs2;
    rv32_word   e1d;
    rv32_word   e2d;
    logic       e1b;
    logic       e2b;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(
    input logic rst, input logic rw, input rv_reg_id_t rd, input rv32_word wd,
    input logic iv, input logic irw, input rv_reg_id_t ird, input logic fl,
    input rv_reg_id_t rs1, input rv_reg_id_t rs2,
    input rv32_word e1d, input rv32_word e2d,
    input logic e1b, input logic e2b, input logic eerr
  );
    vec_t v;
    v.rst = rst; v.rw = rw; v.rd = rd; v.wd = wd;
    v.iv = iv; v.irw = irw; v.ird = ird; v.fl = fl;
    v.rs1 = rs1; v.rs2 = rs2;
    v.e1d = e1d; v.e2d = e2d; v.e1b = e1b; v.e2b = e2b; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.reg_write       = 1'b0;
    bus.rd              = '0;
    bus.wb_data         = '0;
    bus.issue_valid     = 1'b0;
    bus.issue_reg_write = 1'b0;
    bus.issue_rd        = '0;
    bus.flush           = 1'b0;
    bus.rs1             = '0;
    bus.rs2             = '0;
  endtask

  task automatic apply(input vec_t v);
    reset               = v.rst;
    bus.reg_write       = v.rw;
    bus.rd              = v.rd;
    bus.wb_data         = v.wd;
    bus.issue_valid     = v.iv;
    bus.issue_reg_write = v.irw;
    bus.issue_rd        = v.ird;
    bus.flush           = v.fl;
    bus.rs1             = v.rs1;
    bus.rs2             = v.rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Every register reads 0 and idle after reset.
    for (int r = 0; r < 32; r++) begin
      bus.rs1 = rv_reg_id_t'(r);
      bus.rs2 = rv_reg_id_t'(31 - r);
      #1;
      chk("reset_rs1_data", r, bus.rs1_data, 32'h0);
      chk("reset_rs2_data", r, bus.rs2_data, 32'h0);
      chk("reset_rs1_busy", r, 32'(bus.rs1_busy), 32'h0);
      chk("reset_rs2_busy", r, 32'(bus.rs2_busy), 32'h0);
    end
    chk("reset_sb_error", 0, 32'(bus.sb_error), 32'h0);
    tick();

    //         rst rw rd wd            iv irw ird fl rs1 rs2 e1d           e2d           e1b e2b err
    vecs.push_back(mk(0, 1, 0, 'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 'h12345678, 0, 0, 0, 0, 5, 5, 'h12345678, 'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 'h12345678, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 'h12345678, 'h12345678, 0, 0, 0));
    // issue x7 at t, writeback at t+3
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 7, 0, 5, 7, 'h12345678, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 7, 'hA5, 0, 0, 0, 0, 0, 7, 0, 'hA5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 'hA5, 0, 0, 0));
    // issues that must not count
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8, 0, 8, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8, 0, 8, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 8, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0));
    // x9: two issues, two retirements, then simultaneous issue+retire at count 1
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 9, 0, 9, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 9, 0, 9, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 9, 'h11, 0, 0, 0, 0, 9, 0, 'h11, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 'h11, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 9, 'h22, 0, 0, 0, 0, 9, 0, 'h22, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 'h22, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 9, 0, 9, 0, 'h22, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 'h33, 1, 1, 9, 0, 9, 0, 'h33, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 'h33, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 9, 'h44, 0, 0, 0, 0, 9, 0, 'h44, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 'h44, 0, 0, 0, 0));
    // independent updates on different registers in one cycle
    vecs.push_back(mk(0, 1, 11, 'h55, 1, 1, 10, 0, 10, 11, 0, 'h55, 0, 0, 0));
    vecs.push_back(mk(0, 1, 10, 'h66, 1, 1, 11, 0, 10, 11, 'h66, 'h55, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 'h66, 'h55, 0, 1, 0));
    vecs.push_back(mk(0, 1, 11, 'h77, 0, 0, 0, 0, 10, 11, 'h66, 'h77, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 'h66, 'h77, 0, 0, 0));
    // x3 overflow: fourth issue sets sticky error, counter holds at 3
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 3, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 3, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 3, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3, 'h1, 0, 0, 0, 0, 3, 0, 'h1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3, 'h2, 0, 0, 0, 0, 3, 0, 'h2, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3, 'h3, 0, 0, 0, 0, 3, 0, 'h3, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 'h3, 0, 0, 0, 1));
    // reset mid-operation overrides write, issue and flush
    vecs.push_back(mk(1, 1, 12, 'h99, 1, 1, 13, 1, 3, 12, 'h3, 'h99, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 13, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 5, 0, 0, 0, 0, 0));
    // x4: two issues, flush (with discarded issue and a live write), late retirements
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 4, 0, 0, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 4, 0, 0, 4, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 6, 'hBB, 1, 1, 4, 1, 6, 4, 'hBB, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 4, 'hBB, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 'hC1, 0, 0, 0, 0, 6, 4, 'hBB, 'hC1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 'hC2, 0, 0, 0, 0, 6, 4, 'hBB, 'hC2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 4, 'hBB, 'hC2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 4, 0, 6, 4, 'hBB, 'hC2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 4, 'hBB, 'hC2, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4, 'hC3, 0, 0, 0, 0, 6, 4, 'hBB, 'hC3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 4, 'hBB, 'hC3, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #3;
      chk("rs1_data", i, bus.rs1_data, vecs[i].e1d);
      chk("rs2_data", i, bus.rs2_data, vecs[i].e2d);
      chk("rs1_busy", i, 32'(bus.rs1_busy), 32'(vecs[i].e1b));
      chk("rs2_busy", i, 32'(bus.rs2_busy), 32'(vecs[i].e2b));
      chk("sb_error", i, 32'(bus.sb_error), 32'(vecs[i].eerr));
      tick();
    end
    reset = 1'b0;

    // Saturate x20, then a fourth issue under flush must not raise the error.
    drive_idle();
    bus.issue_valid     = 1'b1;
    bus.issue_reg_write = 1'b1;
    bus.issue_rd        = 5'd20;
    repeat (3) tick();
    bus.flush = 1'b1;
    tick();
    drive_idle();
    bus.rs1 = 5'd20;
    #3;
    chk("flush_ovf_busy", 100, 32'(bus.rs1_busy), 32'h0);
    chk("flush_ovf_err", 100, 32'(bus.sb_error), 32'h0);
    tick();

    // Issue and retire x20 together at count 0: count stays 0.
    bus.issue_valid     = 1'b1;
    bus.issue_reg_write = 1'b1;
    bus.issue_rd        = 5'd20;
    bus.reg_write       = 1'b1;
    bus.rd              = 5'd20;
    bus.wb_data         = 32'hE0;
    #3;
    chk("both_bypass", 101, bus.rs1_data, 32'hE0);
    chk("both_busy", 101, 32'(bus.rs1_busy), 32'h0);
    tick();
    drive_idle();
    bus.rs1 = 5'd20;
    #3;
    chk("both_after_busy", 102, 32'(bus.rs1_busy), 32'h0);
    chk("both_after_data", 102, bus.rs1_data, 32'hE0);

    // A single issue from zero is then visible as busy next cycle.
    bus.issue_valid     = 1'b1;
    bus.issue_reg_write = 1'b1;
    bus.issue_rd        = 5'd20;
    tick();
    bus.issue_valid = 1'b0;
    #3;
    chk("reissue_busy", 103, 32'(bus.rs1_busy), 32'h1);
    chk("final_err", 103, 32'(bus.sb_error), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
